// File: rtl/nonrestoring_divider_seq.sv
// rtl/nonrestoring_divider_seq.sv - multi-cycle non-restoring integer divider (optional signed build: DIV_SIGNED_EN)
module nonrestoring_divider_seq #(
    parameter int WIDTH           = 32,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_resultRDY,
    output logic             data_exception,
    output logic             busy
);

    localparam int N  = WIDTH / STEPS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DIVIDE,
        S_FIX,
        S_ZERO,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH:0]   a_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] rem_q;
    logic             rdy_q;
    logic             exc_q;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   a_step;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] a_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

`ifdef DIV_SIGNED_EN
    logic sign_a_q;
    logic sign_b_q;

    // MIN negates to itself, which is exactly its magnitude read as unsigned
    assign mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
`else
    assign mag_a = data_operandA;
    assign mag_b = data_operandB;
`endif

    // STEPS_PER_CYCLE chained shift/add-or-subtract steps; arithmetic wraps in WIDTH+1 bits
    // because every post-step accumulator lies in [-D, D)
    always_comb begin
        a_step = a_q;
        q_step = q_q;
        for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
            if (a_step[WIDTH] == 1'b0) begin
                a_step = {a_step[WIDTH-1:0], q_step[WIDTH-1]} - {1'b0, d_q};
            end else begin
                a_step = {a_step[WIDTH-1:0], q_step[WIDTH-1]} + {1'b0, d_q};
            end
            q_step = {q_step[WIDTH-2:0], ~a_step[WIDTH]};
        end
    end

    // Final remainder correction followed by the sign fix-up of both results
    always_comb begin
        a_fix = a_q[WIDTH] ? (a_q[WIDTH-1:0] + d_q) : a_q[WIDTH-1:0];
`ifdef DIV_SIGNED_EN
        quot_fix = (sign_a_q ^ sign_b_q) ? -q_q : q_q;
        rem_fix  = sign_a_q ? -a_fix : a_fix;
`else
        quot_fix = q_q;
        rem_fix  = a_fix;
`endif
    end

    // Control FSM and datapath registers; a start pulse aborts anything in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            q_q      <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            rem_q    <= '0;
            rdy_q    <= 1'b0;
            exc_q    <= 1'b0;
`ifdef DIV_SIGNED_EN
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
`endif
        end else begin
            rdy_q <= 1'b0;
            if (ctrl_DIV) begin
                a_q   <= '0;
                q_q   <= mag_a;
                d_q   <= mag_b;
                cnt_q <= '0;
                exc_q <= 1'b0;
`ifdef DIV_SIGNED_EN
                sign_a_q <= data_operandA[WIDTH-1];
                sign_b_q <= data_operandB[WIDTH-1];
`endif
                state_q <= (data_operandB == '0) ? S_ZERO : S_LOAD;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                    end
                    S_LOAD: begin
                        state_q <= S_DIVIDE;
                    end
                    S_DIVIDE: begin
                        a_q   <= a_step;
                        q_q   <= q_step;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(N - 1)) begin
                            state_q <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        result_q <= quot_fix;
                        rem_q    <= rem_fix;
                        rdy_q    <= 1'b1;
                        state_q  <= S_DONE;
                    end
                    S_ZERO: begin
                        result_q <= '0;
                        rem_q    <= '0;
                        exc_q    <= 1'b1;
                        rdy_q    <= 1'b1;
                        state_q  <= S_DONE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign data_result    = result_q;
    assign data_remainder = rem_q;
    assign data_resultRDY = rdy_q;
    assign data_exception = exc_q;
    assign busy           = (state_q == S_LOAD) || (state_q == S_DIVIDE) || (state_q == S_FIX);

endmodule

// File: tb/tb_nonrestoring_divider_seq.sv
// tb/tb_nonrestoring_divider_seq.sv - randomized self-checking bench for nonrestoring_divider_seq
module tb_nonrestoring_divider_seq;

    localparam int W   = 32;
    localparam int WIN = 45;

    logic         clock = 1'b0;
    logic         reset;
    logic         ctrl_DIV;
    logic [W-1:0] data_operandA;
    logic [W-1:0] data_operandB;

    logic [W-1:0] res_o  [2];
    logic [W-1:0] rem_o  [2];
    logic         rdy_o  [2];
    logic         exc_o  [2];
    logic         busy_o [2];

    int lat [2] = '{34, 10};
    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    nonrestoring_divider_seq #(.WIDTH(W), .STEPS_PER_CYCLE(1)) dut1 (
        .clock(clock), .reset(reset), .ctrl_DIV(ctrl_DIV),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .data_result(res_o[0]), .data_remainder(rem_o[0]),
        .data_resultRDY(rdy_o[0]), .data_exception(exc_o[0]), .busy(busy_o[0])
    );

    nonrestoring_divider_seq #(.WIDTH(W), .STEPS_PER_CYCLE(4)) dut4 (
        .clock(clock), .reset(reset), .ctrl_DIV(ctrl_DIV),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .data_result(res_o[1]), .data_remainder(rem_o[1]),
        .data_resultRDY(rdy_o[1]), .data_exception(exc_o[1]), .busy(busy_o[1])
    );

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic ex);
        longint sa, sb, qq, rr;
        if (b == 0) begin
            q = 0; r = 0; ex = 1'b1;
        end else begin
            ex = 1'b0;
`ifdef DIV_SIGNED_EN
            sa = $signed(a);
            sb = $signed(b);
`else
            sa = {32'd0, a};
            sb = {32'd0, b};
`endif
            qq = sa / sb;
            rr = sa % sb;
            q  = qq[W-1:0];
            r  = rr[W-1:0];
        end
    endfunction

    task automatic wait_check(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
        logic [W-1:0] eq, er;
        logic         ex;
        int           l [2];
        int           k_at [2];
        int           cnt [2];
        int           bz [2];
        logic [W-1:0] q_at [2];
        logic [W-1:0] r_at [2];
        logic         e_at [2];
        model(a, b, eq, er, ex);
        for (int d = 0; d < 2; d++) begin
            l[d] = ex ? 1 : lat[d];
            k_at[d] = -1; cnt[d] = 0; bz[d] = 0;
            q_at[d] = 'x; r_at[d] = 'x; e_at[d] = 1'bx;
        end
        @(posedge clock); #1;
        ctrl_DIV = 1'b0;
        for (int k = 1; k <= WIN; k++) begin
            @(posedge clock); #1;
            for (int d = 0; d < 2; d++) begin
                if (rdy_o[d] === 1'b1) begin
                    cnt[d]++; k_at[d] = k;
                    q_at[d] = res_o[d]; r_at[d] = rem_o[d]; e_at[d] = exc_o[d];
                end
                if (busy_o[d] !== (!ex && k < l[d])) bz[d]++;
            end
        end
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (cnt[d] != 1 || k_at[d] != l[d]) begin
                n_err++;
                $display("FAIL %s dut%0d rdy: got %0d pulses last at %0d, need 1 at %0d", name, d, cnt[d], k_at[d], l[d]);
            end
            n_vec++;
            if ({q_at[d], r_at[d]} !== {eq, er}) begin
                n_err++;
                $display("FAIL %s dut%0d %h/%h: got q=%h r=%h, need q=%h r=%h", name, d, a, b, q_at[d], r_at[d], eq, er);
            end
            n_vec++;
            if (e_at[d] !== ex) begin
                n_err++;
                $display("FAIL %s dut%0d exception: got %b, need %b", name, d, e_at[d], ex);
            end
            n_vec++;
            if (bz[d] != 0) begin
                n_err++;
                $display("FAIL %s dut%0d busy: %0d wrong cycles, need 0", name, d, bz[d]);
            end
            n_vec++;
            if ({res_o[d], rem_o[d], exc_o[d], rdy_o[d]} !== {eq, er, ex, 1'b0}) begin
                n_err++;
                $display("FAIL %s dut%0d hold: got q=%h r=%h e=%b rdy=%b, need q=%h r=%h e=%b rdy=0",
                         name, d, res_o[d], rem_o[d], exc_o[d], rdy_o[d], eq, er, ex);
            end
        end
    endtask

    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV      = 1'b1;
        wait_check(a, b, name);
    endtask

    task automatic test_reset();
        reset = 1'b1; ctrl_DIV = 1'b1; data_operandA = 32'd5; data_operandB = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if ({res_o[d], rem_o[d], rdy_o[d], exc_o[d], busy_o[d]} !== '0) begin
                n_err++;
                $display("FAIL reset dut%0d: got q=%h r=%h rdy=%b e=%b busy=%b, need all 0",
                         d, res_o[d], rem_o[d], rdy_o[d], exc_o[d], busy_o[d]);
            end
        end
        @(negedge clock);
        reset = 1'b0; ctrl_DIV = 1'b0;
        @(posedge clock); #1;
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if ({rdy_o[d], exc_o[d], busy_o[d]} !== 3'b000) begin
                n_err++;
                $display("FAIL reset_priority dut%0d: got rdy=%b e=%b busy=%b, need 000", d, rdy_o[d], exc_o[d], busy_o[d]);
            end
        end
    endtask

    task automatic test_directed();
        do_div(32'd100, 32'd7, "100/7");
        do_div(-32'sd100, 32'd7, "-100/7");
        do_div(32'd100, -32'sd7, "100/-7");
        do_div(32'h8000_0000, 32'hFFFF_FFFF, "min/-1");
        do_div(32'd5, 32'd0, "5/0");
        do_div(32'd9, 32'd3, "9/3");
        do_div(32'h7FFF_FFFF, 32'd3, "max/3");
        do_div(32'hFFFF_FFFF, 32'd2, "ffffffff/2");
        do_div(32'd3, 32'd100, "small/large");
        do_div(32'h8000_0000, 32'h8000_0000, "min/min");
    endtask

    task automatic test_restart();
        @(negedge clock);
        data_operandA = 32'd1000; data_operandB = 32'd10; ctrl_DIV = 1'b1;
        @(posedge clock); #1;
        ctrl_DIV = 1'b0;
        repeat (9) @(posedge clock);
        do_div(32'd50, 32'd5, "restart");
    endtask

    task automatic test_held_start();
        @(negedge clock);
        data_operandA = 32'd1000; data_operandB = 32'd7; ctrl_DIV = 1'b1;
        @(negedge clock);
        data_operandA = 32'd77; data_operandB = 32'd0;
        @(negedge clock);
        data_operandA = 32'd50; data_operandB = 32'd5;
        wait_check(32'd50, 32'd5, "held");
    endtask

    task automatic test_reset_mid();
        int rdy_seen [2];
        @(negedge clock);
        data_operandA = 32'd1000; data_operandB = 32'd10; ctrl_DIV = 1'b1;
        @(posedge clock); #1;
        ctrl_DIV = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if ({res_o[d], rem_o[d], rdy_o[d], exc_o[d], busy_o[d]} !== '0) begin
                n_err++;
                $display("FAIL reset_mid dut%0d: got q=%h r=%h rdy=%b e=%b busy=%b, need all 0",
                         d, res_o[d], rem_o[d], rdy_o[d], exc_o[d], busy_o[d]);
            end
            rdy_seen[d] = 0;
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (WIN) begin
            @(posedge clock); #1;
            for (int d = 0; d < 2; d++) if (rdy_o[d] !== 1'b0 || busy_o[d] !== 1'b0) rdy_seen[d]++;
        end
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (rdy_seen[d] != 0) begin
                n_err++;
                $display("FAIL reset_mid_quiet dut%0d: %0d cycles with rdy/busy, need 0", d, rdy_seen[d]);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = $urandom_range(1, 15);
                2: b = -$urandom_range(1, 15);
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4: b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            do_div(a, b, "random");
        end
    endtask

    initial begin
        reset = 1'b1; ctrl_DIV = 1'b0; data_operandA = '0; data_operandB = '0;
        test_reset();
        test_directed();
        test_restart();
        test_held_start();
        test_reset_mid();
        test_random();
        do_div(32'd7, 32'd7, "back_to_back");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nonrestoring_divider_seq.md
Name: nonrestoring_divider_seq

Overview:
- Multi-cycle, parametrised non-restoring integer divider for the multdiv unit.
- Holds a 2*WIDTH+1 remainder/quotient register and performs STEPS_PER_CYCLE shift/add-or-subtract steps per clock.
- Adds a control FSM, a final remainder correction, a sign fix-up, a divide-by-zero exception and a ready handshake.
- Result is truncating division: quotient rounds toward zero; remainder takes the dividend's sign.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STEPS_PER_CYCLE and at least 4.
- STEPS_PER_CYCLE, 1, iteration steps per clock; legal values 1, 2, 4.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- ctrl_DIV  input  1  start pulse; operands are sampled on the same edge.
- data_operandA  input  WIDTH  dividend.
- data_operandB  input  WIDTH  divisor.
- data_result  output  WIDTH  quotient.
- data_remainder  output  WIDTH  remainder.
- data_resultRDY  output  1  one-cycle pulse: results valid.
- data_exception  output  1  divide by zero; valid while results are held.
- busy  output  1  high in LOAD/DIVIDE/FIX.

Behaviour:
- Reset: one clock, synchronous, active-high. Drives state=IDLE; data_result, data_remainder, data_resultRDY, data_exception and busy all 0. Reset overrides ctrl_DIV in the same cycle.
- Definitions: N = WIDTH/STEPS_PER_CYCLE. Accumulator A is WIDTH+1 bits, two's complement. Q is WIDTH bits. D is the divisor magnitude, zero-extended to WIDTH+1 bits.
- IDLE: wait for ctrl_DIV. The IDLE/DONE distinction is internal only.
- Start edge, ctrl_DIV=1 in any state including mid-operation: abort any division in flight and capture operands.
  - Capture: A=0, Q=|dividend|, D=|divisor|, the sign bits, and step count=0.
  - Clear data_exception. Go to LOAD.
- LOAD is entered only if the divisor is nonzero; a zero divisor goes straight to ZERO.
- LOAD -> DIVIDE: one cycle.
- DIVIDE: each clock performs STEPS_PER_CYCLE chained steps. Each step:
  - shift {A,Q} left by 1;
  - if the pre-shift A sign = 0, A -= D; else A += D;
  - Q[0] = ~(new A sign).
  - After N clocks, go to FIX.
- FIX, one cycle:
  - if A is negative, A += D;
  - quotient = Q, negated if the operand signs differ;
  - remainder = A[WIDTH-1:0], negated if the dividend is negative;
  - register both outputs, pulse data_resultRDY, go to DONE.
- ZERO, one cycle: data_result=0, data_remainder=0, data_exception=1, pulse data_resultRDY, go to DONE.
- DONE: hold all outputs until the next ctrl_DIV or reset; data_resultRDY=0.
- Latency, counted from the sampling edge of ctrl_DIV to data_resultRDY high:
  - normal: N+2 cycles (1 LOAD + N DIVIDE + 1 FIX); 34 for the defaults.
  - divide by zero: 1 cycle.
- Overflow: MIN/-1 returns quotient MIN (wraps), remainder 0, data_exception=0.
- Magnitude of MIN is 2^(WIDTH-1); it must be representable without loss by using unsigned interpretation.
- A ctrl_DIV held high for several cycles restarts on every cycle it is high; the result reflects the last sampled operands.
- data_result and data_remainder change only in FIX, ZERO or reset; in all other states they keep their previous values.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined: two's-complement signed division, with the sign handling described above.
- Undefined: operands are unsigned, no magnitude or sign fix-up logic is built, and MIN/-1 is an ordinary unsigned divide.
- Latency and handshake are identical in both builds.

Test Plan:
- Default build, DIV_SIGNED_EN defined: 100/7 -> data_result=14, data_remainder=2, data_exception=0, data_resultRDY high exactly 34 cycles after the start edge, for one cycle.
- Signed, DIV_SIGNED_EN defined: -100/7 -> 0xFFFFFFF2, remainder 0xFFFFFFFE. 100/-7 -> 0xFFFFFFF2, remainder 2. 0x80000000/0xFFFFFFFF -> 0x80000000, remainder 0, no exception.
- Divide by zero: 5/0 -> data_resultRDY one cycle after start, data_exception=1, result and remainder 0. Next start with 9/3 -> exception clears, result 3.
- Restart and reset: start 1000/10, re-pulse ctrl_DIV with 50/5 at cycle 10 -> a single RDY 34 cycles after the second start, result 10. Assert reset mid-DIVIDE -> no RDY, all outputs 0.
- STEPS_PER_CYCLE=4, WIDTH=32: 0x7FFFFFFF/3 -> 0x2AAAAAAA, remainder 1, latency 10 cycles.
- DIV_SIGNED_EN undefined: 0xFFFFFFFF/2 -> 0x7FFFFFFF, remainder 1.
